// File: rtl/mtx_mult_sched.sv
// mtx_mult_sched: sequences C = A x W, issuing RAM reads / MAC operand pairs and writing results row-major.
module mtx_mult_sched #(
  parameter int MAX_DIM = 16,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [4:0]        dim_n,
  input  logic              mac_ready,
  input  logic              mac_res_valid,
  input  logic [DATA_W-1:0] mac_res_data,
  output logic [ADDR_W-1:0] ram_a_addr,
  output logic              ram_a_rden,
  output logic [ADDR_W-1:0] ram_w_addr,
  output logic              ram_w_rden,
  output logic              mac_in_valid,
  output logic              mac_first,
  output logic              mac_last,
  output logic [ADDR_W-1:0] res_wr_addr,
  output logic [DATA_W-1:0] res_wr_data,
  output logic              res_wren,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [3:0]        state_val
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state;
  logic [4:0] n, nm1, i, j, k, ri, rj;
  logic [ADDR_W-1:0] a_reg, w_reg, a_base, res_cnt, n_a;
  logic all_wr, issue, k_last, j_last, i_last, dim_ok;
  assign nm1 = n - 5'd1;
  assign n_a = ADDR_W'(n);
  assign issue = state == ISSUE && mac_ready;
  assign k_last = k == nm1;
  assign j_last = j == nm1;
  assign i_last = i == nm1;
  assign dim_ok = dim_n != 5'd0 && 32'(dim_n) <= MAX_DIM;
  assign ram_a_rden = issue;
  assign ram_w_rden = issue;
  assign ram_a_addr = a_reg;
  assign ram_w_addr = w_reg;
  assign state_val = {2'b00, state};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      n <= '0;
      i <= '0;
      j <= '0;
      k <= '0;
      ri <= '0;
      rj <= '0;
      a_reg <= '0;
      w_reg <= '0;
      a_base <= '0;
      res_cnt <= '0;
      all_wr <= 1'b0;
      mac_in_valid <= 1'b0;
      mac_first <= 1'b0;
      mac_last <= 1'b0;
      res_wr_addr <= '0;
      res_wr_data <= '0;
      res_wren <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      err <= 1'b0;
      done <= 1'b0;
      res_wren <= 1'b0;
      mac_in_valid <= issue;
      mac_first <= issue && k == 5'd0;
      mac_last <= issue && k_last;
      // result path runs independently of issue; strobes past the n*n-th are dropped
      if ((state == ISSUE || state == DRAIN) && mac_res_valid && !all_wr) begin
        res_wr_data <= mac_res_data;
        res_wr_addr <= res_cnt;
        res_wren <= 1'b1;
        res_cnt <= res_cnt + 1'b1;
        rj <= rj == nm1 ? 5'd0 : rj + 5'd1;
        ri <= rj == nm1 ? ri + 5'd1 : ri;
        all_wr <= ri == nm1 && rj == nm1;
      end
      case (state)
        IDLE: if (start) begin
          if (dim_ok) begin
            n <= dim_n;
            i <= '0;
            j <= '0;
            k <= '0;
            ri <= '0;
            rj <= '0;
            a_reg <= '0;
            w_reg <= '0;
            a_base <= '0;
            res_cnt <= '0;
            all_wr <= 1'b0;
            busy <= 1'b1;
            state <= ISSUE;
          end else err <= 1'b1;
        end
        ISSUE: if (mac_ready) begin
          // a = i*n+k and w = k*n+j tracked with adders only
          if (!k_last) begin
            k <= k + 5'd1;
            a_reg <= a_reg + 1'b1;
            w_reg <= w_reg + n_a;
          end else if (!j_last) begin
            k <= '0;
            j <= j + 5'd1;
            a_reg <= a_base;
            w_reg <= ADDR_W'(j + 5'd1);
          end else begin
            k <= '0;
            j <= '0;
            i <= i + 5'd1;
            a_base <= a_base + n_a;
            a_reg <= a_base + n_a;
            w_reg <= '0;
            if (i_last) state <= DRAIN;
          end
        end
        DRAIN: if (all_wr) begin
          state <= DONE;
          done <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mtx_mult_sched.sv
// tb_mtx_mult_sched: scoreboard bench with RAM/MAC models and a loop-nest reference for issues and results.
module tb_mtx_mult_sched;
  localparam int LAT = 7;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, mac_ready = 1'b1;
  logic [4:0] dim_n = '0;
  logic mac_res_valid = 1'b0;
  logic [31:0] mac_res_data = '0;
  logic [7:0] ram_a_addr, ram_w_addr, res_wr_addr;
  logic ram_a_rden, ram_w_rden, mac_in_valid, mac_first, mac_last, res_wren, busy, done, err;
  logic [31:0] res_wr_data;
  logic [3:0] state_val;

  mtx_mult_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dim_n(dim_n), .mac_ready(mac_ready),
    .mac_res_valid(mac_res_valid), .mac_res_data(mac_res_data),
    .ram_a_addr(ram_a_addr), .ram_a_rden(ram_a_rden), .ram_w_addr(ram_w_addr), .ram_w_rden(ram_w_rden),
    .mac_in_valid(mac_in_valid), .mac_first(mac_first), .mac_last(mac_last),
    .res_wr_addr(res_wr_addr), .res_wr_data(res_wr_data), .res_wren(res_wren),
    .busy(busy), .done(done), .err(err), .state_val(state_val)
  );

  always #5 clk = ~clk;

  typedef struct {logic [7:0] a; logic [7:0] w; logic f; logic l;} iss_t;
  typedef struct {logic [7:0] ad; logic [31:0] d;} wr_t;
  typedef struct {int t; logic [31:0] v;} mp_t;
  iss_t iq[$];
  wr_t wq[$];
  mp_t pipe[$];
  logic [31:0] amem[256], wmem[256];
  logic [31:0] ra_q, rw_q, acc;
  int checks = 0, errors = 0;
  int cyc = 0, mcyc = 0, last_wr = 0, done_cyc = 0, done_cnt = 0, err_cnt = 0, rden_cnt = 0;
  int rmode = 0;
  logic tog = 1'b0, prev_rden = 1'b0, pf = 1'b0, pl = 1'b0;
  iss_t e;
  wr_t ew;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // RAMs with 1-cycle read latency and an integer multiply-accumulate MAC
  always @(posedge clk) begin
    if (ram_a_rden) ra_q <= amem[ram_a_addr];
    if (ram_w_rden) rw_q <= wmem[ram_w_addr];
  end

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      pipe.delete();
      mac_res_valid <= 1'b0;
    end else begin
      if (mac_in_valid) begin
        acc = (mac_first ? 32'd0 : acc) + ra_q * rw_q;
        if (mac_last) pipe.push_back('{cyc + LAT, acc});
      end
      if (pipe.size() > 0 && pipe[0].t <= cyc) begin
        mac_res_valid <= 1'b1;
        mac_res_data <= pipe[0].v;
        void'(pipe.pop_front());
      end else mac_res_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    tog = ~tog;
    mac_ready = rmode == 0 ? 1'b1 : rmode == 1 ? tog : 1'($urandom % 2);
  end

  always @(negedge clk) begin
    #1;
    mcyc++;
    if (rst_n) begin
      chk("in_valid", 64'(mac_in_valid), 64'(prev_rden));
      if (mac_in_valid) chk("first_last", 64'({mac_first, mac_last}), 64'({pf, pl}));
      prev_rden = ram_a_rden;
      if (ram_a_rden) begin
        rden_cnt++;
        chk("issue_pending", 64'(iq.size() > 0), 64'(1));
        if (iq.size() > 0) begin
          e = iq.pop_front();
          chk("issue", 64'({ram_a_addr, ram_w_addr, ram_w_rden, mac_ready, state_val}),
              64'({e.a, e.w, 1'b1, 1'b1, 4'd1}));
          pf = e.f;
          pl = e.l;
        end
      end
      if (res_wren) begin
        chk("wr_pending", 64'(wq.size() > 0), 64'(1));
        if (wq.size() > 0) begin
          ew = wq.pop_front();
          chk("wr", 64'({res_wr_addr, res_wr_data}), 64'({ew.ad, ew.d}));
        end
        last_wr = mcyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = mcyc;
        chk("done_busy", 64'({busy, state_val}), 64'({1'b1, 4'd3}));
      end
      if (err) err_cnt++;
    end else prev_rden = 1'b0;
  end

  task automatic load(input int n, input bit ident);
    logic [31:0] s;
    for (int x = 0; x < n * n; x++) begin
      amem[x] = $urandom;
      wmem[x] = ident ? 32'((x / n) == (x % n)) : $urandom;
    end
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        s = 0;
        for (int k = 0; k < n; k++) begin
          iq.push_back('{8'(i * n + k), 8'(k * n + j), k == 0, k == n - 1});
          s += amem[i * n + k] * wmem[k * n + j];
        end
        wq.push_back('{8'(i * n + j), s});
      end
  endtask

  task automatic pulse_start(input int d);
    @(negedge clk);
    start = 1'b1;
    dim_n = 5'(d);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(input int n, input int mode, input bit ident, input bit extra);
    int d0, c;
    rmode = mode;
    load(n, ident);
    d0 = done_cnt;
    pulse_start(n);
    if (extra) begin
      @(negedge clk);
      start = 1'b1;
      dim_n = 5'd3;
      @(negedge clk);
      start = 1'b0;
    end
    c = 0;
    while (done_cnt == d0 && c < 4 * n * n * n + 200) begin
      @(negedge clk);
      c++;
    end
    #2;
    chk("done_once", 64'(done_cnt), 64'(d0 + 1));
    chk("issues_left", 64'(iq.size()), 64'(0));
    chk("writes_left", 64'(wq.size()), 64'(0));
    chk("done_delay", 64'(done_cyc - last_wr), 64'(1));
    chk("idle_after", 64'({busy, state_val}), 64'(0));
    iq.delete();
    wq.delete();
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ctl"}, 64'({ram_a_addr, ram_w_addr, ram_a_rden, ram_w_rden, mac_in_valid, mac_first,
        mac_last, res_wr_addr, res_wren, busy, done, err, state_val}), 64'(0));
    chk({nm, "_data"}, 64'(res_wr_data), 64'(0));
  endtask

  initial begin
    int e0, r0;
    repeat (3) @(negedge clk);
    #2;
    chk_zero("reset");
    rst_n = 1'b1;
    run(2, 0, 1'b0, 1'b0);
    run(4, 0, 1'b1, 1'b0);
    run(3, 1, 1'b0, 1'b0);
    e0 = err_cnt;
    r0 = rden_cnt;
    pulse_start(0);
    @(negedge clk);
    #2;
    chk("err_dim0", 64'({err_cnt, busy}), 64'({e0 + 1, 1'b0}));
    pulse_start(17);
    repeat (2) @(negedge clk);
    #2;
    chk("err_dim17", 64'({err_cnt, busy}), 64'({e0 + 2, 1'b0}));
    chk("err_no_rden", 64'(rden_cnt), 64'(r0));
    rmode = 0;
    load(4, 1'b0);
    pulse_start(4);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #2;
    chk_zero("midreset");
    iq.delete();
    wq.delete();
    rst_n = 1'b1;
    run(2, 0, 1'b0, 1'b0);
    run(1, 2, 1'b0, 1'b1);
    repeat (4) run($urandom_range(1, 7), $urandom_range(0, 2), 1'b0, 1'b0);
    run(16, 0, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
